// File: rtl/sync_fifo_pkg.sv
// Shared constants and helpers for the synchronous FIFO controller and its wrapper.
package sync_fifo_pkg;

  localparam int unsigned DEF_ADDR_WIDTH = 2;
  localparam int unsigned DEF_DATA_WIDTH = 8;

  // Pointers carry one extra wrap bit above the storage address.
  function automatic int unsigned ptr_width(input int unsigned addr_width);
    return addr_width + 1;
  endfunction

endpackage

// File: rtl/fifo_ptr.sv
// Wrapping pointer with enable and synchronous reset; also exposes its next value.
module fifo_ptr #(
  parameter int unsigned PTR_W = 3
) (
  input  logic             i_Clk,
  input  logic             i_Rst,
  input  logic             i_En,
  output logic [PTR_W-1:0] o_Ptr,
  output logic [PTR_W-1:0] o_Ptr_Nxt_c
);

  assign o_Ptr_Nxt_c = i_En ? o_Ptr + PTR_W'(1) : o_Ptr;

  always_ff @(posedge i_Clk) begin
    if (i_Rst) o_Ptr <= '0;
    else       o_Ptr <= o_Ptr_Nxt_c;
  end

endmodule

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO: controller plus storage array.
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  i_Clk,
  input  logic                  i_Rst,
  input  logic                  i_Wr_Req,
  input  logic [DATA_WIDTH-1:0] i_Wr_Data,
  input  logic                  i_Rd_Req,
  input  logic                  i_Clr_Err,
  output logic [DATA_WIDTH-1:0] o_Rd_Data_c,
  output logic                  o_Full,
  output logic                  o_Empty,
  output logic                  o_Almost_Full,
  output logic                  o_Almost_Empty,
  output logic [ADDR_WIDTH:0]   o_Count,
  output logic                  o_Overflow,
  output logic                  o_Underflow
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  sync_fifo_ctrl #(.ADDR_WIDTH(ADDR_WIDTH)) u_ctrl (
    .i_Clk          (i_Clk),
    .i_Rst          (i_Rst),
    .i_Wr_Req       (i_Wr_Req),
    .i_Rd_Req       (i_Rd_Req),
    .i_Clr_Err      (i_Clr_Err),
    .o_Wr_En        (wr_en),
    .o_Wr_Addr      (wr_addr),
    .o_Rd_Addr      (rd_addr),
    .o_Full         (o_Full),
    .o_Empty        (o_Empty),
    .o_Almost_Full  (o_Almost_Full),
    .o_Almost_Empty (o_Almost_Empty),
    .o_Count        (o_Count),
    .o_Overflow     (o_Overflow),
    .o_Underflow    (o_Underflow)
  );

  always_ff @(posedge i_Clk) begin
    if (wr_en) mem[wr_addr] <= i_Wr_Data;
  end

  // Head entry is visible combinationally at the read address.
  assign o_Rd_Data_c = mem[rd_addr];

endmodule

// File: rtl/sync_fifo_ctrl.sv
// Synchronous FIFO controller: pointers, occupancy, status and sticky error flags.
module sync_fifo_ctrl
  import sync_fifo_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned AFULL_LVL  = (2 ** ADDR_WIDTH) - 1,
  parameter int unsigned AEMPTY_LVL = 1
) (
  input  logic                  i_Clk,
  input  logic                  i_Rst,
  input  logic                  i_Wr_Req,
  input  logic                  i_Rd_Req,
  input  logic                  i_Clr_Err,
  output logic                  o_Wr_En,
  output logic [ADDR_WIDTH-1:0] o_Wr_Addr,
  output logic [ADDR_WIDTH-1:0] o_Rd_Addr,
  output logic                  o_Full,
  output logic                  o_Empty,
  output logic                  o_Almost_Full,
  output logic                  o_Almost_Empty,
  output logic [ADDR_WIDTH:0]   o_Count,
  output logic                  o_Overflow,
  output logic                  o_Underflow
);

  localparam int unsigned PTR_W = ptr_width(ADDR_WIDTH);
  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  logic             wr_ok;
  logic             rd_ok;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr_nxt;
  logic [PTR_W-1:0] rd_ptr_nxt;
  logic [PTR_W-1:0] count_nxt;
  logic             full_nxt;
  logic             empty_nxt;

  // Accept decisions look only at registered flags.
  assign wr_ok   = i_Wr_Req & ~o_Full;
  assign rd_ok   = i_Rd_Req & ~o_Empty;
  assign o_Wr_En = wr_ok;

  fifo_ptr #(.PTR_W(PTR_W)) u_wr_ptr (
    .i_Clk       (i_Clk),
    .i_Rst       (i_Rst),
    .i_En        (wr_ok),
    .o_Ptr       (wr_ptr),
    .o_Ptr_Nxt_c (wr_ptr_nxt)
  );

  fifo_ptr #(.PTR_W(PTR_W)) u_rd_ptr (
    .i_Clk       (i_Clk),
    .i_Rst       (i_Rst),
    .i_En        (rd_ok),
    .o_Ptr       (rd_ptr),
    .o_Ptr_Nxt_c (rd_ptr_nxt)
  );

  assign o_Wr_Addr = wr_ptr[ADDR_WIDTH-1:0];
  assign o_Rd_Addr = rd_ptr[ADDR_WIDTH-1:0];

  always_comb begin
    count_nxt = o_Count;
    empty_nxt = (wr_ptr_nxt == rd_ptr_nxt);
    full_nxt  = (wr_ptr_nxt[ADDR_WIDTH-1:0] == rd_ptr_nxt[ADDR_WIDTH-1:0]) &&
                (wr_ptr_nxt[ADDR_WIDTH] != rd_ptr_nxt[ADDR_WIDTH]);
    case ({wr_ok, rd_ok})
      2'b10:   count_nxt = o_Count + PTR_W'(1);
      2'b01:   count_nxt = o_Count - PTR_W'(1);
      default: count_nxt = o_Count;
    endcase
  end

  // Status flags are registered from the next-state pointers and count.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      o_Count        <= '0;
      o_Empty        <= 1'b1;
      o_Full         <= 1'b0;
      o_Almost_Empty <= 1'b1;
      o_Almost_Full  <= 1'b0;
    end else begin
      o_Count        <= count_nxt;
      o_Empty        <= empty_nxt;
      o_Full         <= full_nxt;
      o_Almost_Empty <= (count_nxt <= PTR_W'(AEMPTY_LVL));
      o_Almost_Full  <= (count_nxt >= PTR_W'(AFULL_LVL));
    end
  end

  // Sticky errors: a new event wins over a same-cycle clear.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      o_Overflow  <= 1'b0;
      o_Underflow <= 1'b0;
    end else begin
      if (i_Wr_Req && o_Full) o_Overflow <= 1'b1;
      else if (i_Clr_Err)     o_Overflow <= 1'b0;
      if (i_Rd_Req && o_Empty) o_Underflow <= 1'b1;
      else if (i_Clr_Err)      o_Underflow <= 1'b0;
    end
  end

  initial begin : unused_depth_guard
  end

endmodule

// File: doc/sync_fifo_ctrl.md
SYNC_FIFO_CTRL -- requirements
Module: sync_fifo_ctrl

Interface
REQ-001 Parameter ADDR_WIDTH, default 2, shall set the depth DEPTH = 2**ADDR_WIDTH and match the storage array's address width.
REQ-002 Parameter AFULL_LVL, default DEPTH-1, shall be the occupancy at or above which o_Almost_Full is asserted.
REQ-003 Parameter AEMPTY_LVL, default 1, shall be the occupancy at or below which o_Almost_Empty is asserted.
REQ-004 i_Clk  in  1  shall be the single clock; all state updates on its rising edge.
REQ-005 i_Rst  in  1  shall be the reset: synchronous, active-high.
REQ-006 i_Wr_Req  in  1  shall be the producer write request.
REQ-007 i_Rd_Req  in  1  shall be the consumer read request (pop).
REQ-008 i_Clr_Err  in  1  shall clear the sticky error flags.
REQ-009 o_Wr_En  out  1  shall be the gated write enable to the storage array.
REQ-010 o_Wr_Addr  out  ADDR_WIDTH  shall be the storage write address.
REQ-011 o_Rd_Addr  out  ADDR_WIDTH  shall be the storage read address; the head entry appears combinationally on the storage read port.
REQ-012 o_Full, o_Empty, o_Almost_Full, o_Almost_Empty  out  1 each  shall be the status flags.
REQ-013 o_Count  out  ADDR_WIDTH+1  shall be the current occupancy, 0..DEPTH.
REQ-014 o_Overflow, o_Underflow  out  1 each  shall be the sticky error flags.

Function
REQ-015 Write and read pointers shall be ADDR_WIDTH+1 bits; the LSBs drive o_Wr_Addr/o_Rd_Addr and the MSB is the wrap bit.
REQ-016 Write accept wr_ok = i_Wr_Req & ~o_Full; read accept rd_ok = i_Rd_Req & ~o_Empty; both shall be decided on registered flags only.
REQ-017 o_Wr_En shall equal wr_ok combinationally; a rejected write shall never reach storage.
REQ-018 On wr_ok the write pointer shall increment by 1 at the clock edge; on rd_ok the read pointer shall increment by 1; both shall wrap modulo 2**(ADDR_WIDTH+1).
REQ-019 o_Empty shall be asserted when the pointers are fully equal; o_Full when the LSBs are equal and the MSBs differ; both shall be registered, with no combinational path from the requests.
REQ-020 o_Count shall be registered: +1 on wr_ok only, -1 on rd_ok only, unchanged on both or neither; it shall never exceed DEPTH or go below 0.
REQ-021 Simultaneous request when full: read accepted, write rejected; the next cycle shows count DEPTH-1 and o_Full=0.
REQ-022 Simultaneous request when empty: write accepted, read rejected; the next cycle shows count 1 and o_Empty=0.
REQ-023 Simultaneous accepted read and write at 0<count<DEPTH: both pointers advance, count and flags unchanged.
REQ-024 o_Almost_Full = (count >= AFULL_LVL); o_Almost_Empty = (count <= AEMPTY_LVL); both registered and derived from the next-state count.
REQ-025 o_Overflow shall set the cycle after i_Wr_Req & o_Full; o_Underflow shall set the cycle after i_Rd_Req & o_Empty; both shall hold until i_Clr_Err or reset.
REQ-026 Clear priority: if i_Clr_Err and a new error event occur in the same cycle, the flag shall be set (set wins).
REQ-027 Read data shall be valid whenever o_Empty=0, first-word fall-through, with 0-cycle read latency from o_Rd_Addr; a write becomes readable the cycle after wr_ok.

Reset
REQ-028 When i_Rst is high at a clock edge: both pointers 0, o_Count 0, o_Empty 1, o_Full 0, o_Almost_Empty 1, o_Almost_Full 0, o_Overflow 0, o_Underflow 0.
REQ-029 Reset shall take priority over all requests; o_Wr_En shall be 0 while o_Full is 0 and i_Wr_Req is 0, and reset mid-operation discards all contents.

Structure
REQ-030 Shared package sync_fifo_pkg shall hold the default ADDR_WIDTH/DATA_WIDTH constants and the pointer-width constant or function.
REQ-031 One sub-module, fifo_ptr (a wrapping ADDR_WIDTH+1 incrementer with enable and sync reset), shall be instantiated twice, once per pointer.
REQ-032 The top-level sync FIFO shall instantiate sync_fifo_ctrl and the storage array, wiring o_Wr_En/o_Wr_Addr/o_Rd_Addr directly.

Verification (ADDR_WIDTH=2, DEPTH=4, defaults)
REQ-033 Reset, then 4 writes -> o_Count 1,2,3,4; o_Almost_Full at count 3; o_Full=1 after the 4th write; o_Wr_Addr 0,1,2,3.
REQ-034 Full, then a 5th write -> o_Wr_En=0, o_Overflow=1 next cycle; i_Clr_Err -> o_Overflow=0 next cycle.
REQ-035 Full, then simultaneous read+write -> read only; o_Count=3 and o_Full=0 next cycle.
REQ-036 Empty, then read -> o_Underflow=1; simultaneous read+write on empty -> o_Count=1 and o_Empty=0.
REQ-037 Run 10 cycles of continuous read+write at count 2 -> count stays 2 and the addresses wrap 3->0 without flag glitches.
REQ-038 Reset asserted at count 3 -> next cycle o_Count=0, o_Empty=1, both addresses 0.
